// File: rtl/traffic_phase_scheduler_pkg.sv
// ----------------------------------------------------------------------------
// traffic_pkg
//   Shared types and constants for the intersection phase scheduler.
//   phase_e : phase encoding, also driven on the debug/display phase port.
//   LT_*    : one-hot light patterns, bit order {G,Y,R}, active-high.
//   next_day_phase : fixed day-cycle ring
//                    MAIN_G -> MAIN_Y -> RED1 -> SIDE_G -> SIDE_Y -> RED2.
// ----------------------------------------------------------------------------
package traffic_pkg;

    typedef enum logic [2:0] {
        MAIN_G = 3'd0,
        MAIN_Y = 3'd1,
        RED1   = 3'd2,
        SIDE_G = 3'd3,
        SIDE_Y = 3'd4,
        RED2   = 3'd5,
        NIGHT  = 3'd6
    } phase_e;

    localparam logic [2:0] LT_R   = 3'b001;
    localparam logic [2:0] LT_Y   = 3'b010;
    localparam logic [2:0] LT_G   = 3'b100;
    localparam logic [2:0] LT_OFF = 3'b000;

    // Successor in the day cycle. NIGHT and illegal codes fall back to RED2
    // so that any odd state re-enters the cycle through a clearance interval.
    function automatic phase_e next_day_phase(input phase_e p);
        phase_e n;
        case (p)
            MAIN_G:  n = MAIN_Y;
            MAIN_Y:  n = RED1;
            RED1:    n = SIDE_G;
            SIDE_G:  n = SIDE_Y;
            SIDE_Y:  n = RED2;
            RED2:    n = MAIN_G;
            default: n = RED2;
        endcase
        return n;
    endfunction

endpackage

// File: rtl/traffic_phase_scheduler_bin2bcd.sv
// ----------------------------------------------------------------------------
// bin2bcd_99
//   Combinational binary-to-BCD converter for the range 0..99.
//   Inputs above 99 saturate to 99 so the display never shows a non-BCD digit.
// Ports
//   bin   in  7  binary value
//   tens  out 4  BCD tens digit
//   ones  out 4  BCD ones digit
// ----------------------------------------------------------------------------
module bin2bcd_99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    logic [6:0] val;
    logic [3:0] t;

    // Tens digit is found by comparing against 10..90; the remainder is the
    // ones digit. No divider is needed for such a small range.
    always_comb begin
        val = (bin > 7'd99) ? 7'd99 : bin;
        t   = 4'd0;
        for (int i = 1; i <= 9; i++) begin
            if (val >= 7'(10 * i)) begin
                t = 4'(i);
            end
        end
        tens = t;
        ones = 4'(val - 7'(10 * t));
    end

endmodule

// File: rtl/traffic_phase_scheduler.sv
// ----------------------------------------------------------------------------
// traffic_phase_scheduler
//   Phase sequencer for a two-road (main/side) intersection with pedestrian
//   request shortening of main green and a night flashing-yellow mode.
//   All timing advances only on clk edges where tick_1hz is high.
//
// Handshake/timing contract: ped_req is a 1-cycle pulse accepted on any clk;
//   night_mode is a level sampled only at the end of RED2 (entry) and at
//   NIGHT ticks (exit). Lights and BCD digits are registered from the phase
//   state, so they follow a state change by exactly one clk.
//
// Ports
//   clk          in   1  system clock
//   rst          in   1  asynchronous reset, active-high
//   tick_1hz     in   1  one-cycle time-base strobe
//   ped_req      in   1  pedestrian request pulse
//   night_mode   in   1  request flashing-yellow operation
//   main_light   out  3  one-hot {G,Y,R}, registered
//   side_light   out  3  one-hot {G,Y,R}, registered
//   remain_tens  out  4  BCD tens of remaining ticks, registered
//   remain_ones  out  4  BCD ones of remaining ticks, registered
//   ped_pending  out  1  latched pedestrian request
//   phase        out  3  current phase (debug/display)
// ----------------------------------------------------------------------------
module traffic_phase_scheduler
    import traffic_pkg::*;
#(
    parameter int unsigned T_MAIN_G  = 25,
    parameter int unsigned T_SIDE_G  = 20,
    parameter int unsigned T_YEL     = 3,
    parameter int unsigned T_ALL_RED = 2,
    parameter int unsigned T_MIN_G   = 10,
    parameter int unsigned CW        = 7
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_1hz,
    input  logic       ped_req,
    input  logic       night_mode,
    output logic [2:0] main_light,
    output logic [2:0] side_light,
    output logic [3:0] remain_tens,
    output logic [3:0] remain_ones,
    output logic       ped_pending,
    output phase_e     phase
);

    // ------------------------------------------------------------------
    // Parameter sanity: durations must fit the two-digit display, be
    // non-zero, and the minimum green must not exceed the full green.
    // ------------------------------------------------------------------
    if (T_MAIN_G > 99 || T_SIDE_G > 99 || T_YEL > 99 || T_ALL_RED > 99 || T_MIN_G > 99) begin : g_bad_range
        $error("traffic_phase_scheduler: all durations must be <= 99");
    end
    if (T_MAIN_G == 0 || T_SIDE_G == 0 || T_YEL == 0 || T_ALL_RED == 0) begin : g_bad_zero
        $error("traffic_phase_scheduler: phase durations must be >= 1");
    end
    if (T_MIN_G > T_MAIN_G) begin : g_bad_min
        $error("traffic_phase_scheduler: T_MIN_G must be <= T_MAIN_G");
    end
    if (CW < 7) begin : g_bad_cw
        $error("traffic_phase_scheduler: CW must be >= 7 to hold 99");
    end

    localparam logic [CW-1:0] D_MAIN_G  = CW'(T_MAIN_G);
    localparam logic [CW-1:0] D_SIDE_G  = CW'(T_SIDE_G);
    localparam logic [CW-1:0] D_YEL     = CW'(T_YEL);
    localparam logic [CW-1:0] D_ALL_RED = CW'(T_ALL_RED);
    localparam logic [CW-1:0] D_MIN_G   = CW'(T_MIN_G);
    localparam logic [CW-1:0] D_ONE     = CW'(1);

    localparam logic [3:0] RST_TENS = 4'(T_ALL_RED / 10);
    localparam logic [3:0] RST_ONES = 4'(T_ALL_RED % 10);

    // Reload value on entry to a phase. NIGHT has no countdown.
    function automatic logic [CW-1:0] dur_of(input phase_e p);
        logic [CW-1:0] d;
        case (p)
            MAIN_G:         d = D_MAIN_G;
            MAIN_Y, SIDE_Y: d = D_YEL;
            SIDE_G:         d = D_SIDE_G;
            NIGHT:          d = '0;
            default:        d = D_ALL_RED;
        endcase
        return d;
    endfunction

    // ------------------------------------------------------------------
    // Phase state
    // ------------------------------------------------------------------
    phase_e        phase_q;
    logic [CW-1:0] remain_q;
    logic          blink_q;
    logic          ped_q;

    logic [CW-1:0] elapsed;
    logic          phase_end;
    logic          ped_cut;
    logic          enter_side_g;

    logic [2:0]    main_lt;
    logic [2:0]    side_lt;
    logic [3:0]    bcd_tens;
    logic [3:0]    bcd_ones;

    // remain counts D..1, so the last tick of a phase sees remain==1.
    // "<=" also catches a stray zero so a day phase can never wrap to max.
    assign phase_end    = (remain_q <= D_ONE);

    // Ticks already spent in MAIN_G including the current one. remain never
    // exceeds D_MAIN_G while in MAIN_G, so this cannot underflow.
    assign elapsed      = D_MAIN_G - remain_q + D_ONE;
    assign ped_cut      = ped_q && (elapsed >= D_MIN_G);

    assign enter_side_g = tick_1hz && (phase_q == RED1) && phase_end;

    assign ped_pending  = ped_q;
    assign phase        = phase_q;

    // ------------------------------------------------------------------
    // Light decode from current state; registered below.
    // ------------------------------------------------------------------
    always_comb begin
        main_lt = LT_R;
        side_lt = LT_R;
        case (phase_q)
            MAIN_G: main_lt = LT_G;
            MAIN_Y: main_lt = LT_Y;
            SIDE_G: side_lt = LT_G;
            SIDE_Y: side_lt = LT_Y;
            NIGHT: begin
                main_lt = blink_q ? LT_Y : LT_OFF;
                side_lt = blink_q ? LT_Y : LT_OFF;
            end
            default: begin
                main_lt = LT_R;
                side_lt = LT_R;
            end
        endcase
    end

    bin2bcd_99 u_bcd (
        .bin  (remain_q[6:0]),
        .tens (bcd_tens),
        .ones (bcd_ones)
    );

    // ------------------------------------------------------------------
    // Phase FSM with registered outputs
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q     <= RED2;
            remain_q    <= D_ALL_RED;
            blink_q     <= 1'b0;
            ped_q       <= 1'b0;
            main_light  <= LT_R;
            side_light  <= LT_R;
            remain_tens <= RST_TENS;
            remain_ones <= RST_ONES;
        end else begin
            main_light  <= main_lt;
            side_light  <= side_lt;
            remain_tens <= bcd_tens;
            remain_ones <= bcd_ones;

            // A new request wins over the clear so a request arriving on the
            // very tick that starts SIDE_G is kept for the next main green.
            if (ped_req) begin
                ped_q <= 1'b1;
            end else if (enter_side_g) begin
                ped_q <= 1'b0;
            end

            case (phase_q)
                MAIN_G: begin
                    if (tick_1hz) begin
                        if (ped_cut || phase_end) begin
                            phase_q  <= MAIN_Y;
                            remain_q <= D_YEL;
                        end else begin
                            remain_q <= remain_q - D_ONE;
                        end
                    end
                end

                MAIN_Y, RED1, SIDE_G, SIDE_Y: begin
                    if (tick_1hz) begin
                        if (phase_end) begin
                            phase_q  <= next_day_phase(phase_q);
                            remain_q <= dur_of(next_day_phase(phase_q));
                        end else begin
                            remain_q <= remain_q - D_ONE;
                        end
                    end
                end

                // End of RED2 is the only point where night mode is entered,
                // so a green or yellow is never cut short by night_mode.
                RED2: begin
                    if (tick_1hz) begin
                        if (phase_end) begin
                            if (night_mode) begin
                                phase_q  <= NIGHT;
                                remain_q <= '0;
                                blink_q  <= ~blink_q;
                            end else begin
                                phase_q  <= MAIN_G;
                                remain_q <= D_MAIN_G;
                            end
                        end else begin
                            remain_q <= remain_q - D_ONE;
                        end
                    end
                end

                // Leaving night always goes through a full all-red interval.
                NIGHT: begin
                    if (tick_1hz) begin
                        if (night_mode) begin
                            blink_q <= ~blink_q;
                        end else begin
                            phase_q  <= RED2;
                            remain_q <= D_ALL_RED;
                            blink_q  <= 1'b0;
                        end
                    end
                end

                default: begin
                    phase_q  <= RED2;
                    remain_q <= D_ALL_RED;
                    blink_q  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_traffic_phase_scheduler.sv
// ----------------------------------------------------------------------------
// tb_traffic_phase_scheduler
//   Directed bench for traffic_phase_scheduler with default parameters and a
//   tick_1hz strobe every 4 clocks. Expected phases, countdowns and lights are
//   hand-derived from the phase table (25/3/2/20/3/2 ticks).
// ----------------------------------------------------------------------------
module tb_traffic_phase_scheduler;
    import traffic_pkg::*;

    logic       clk;
    logic       rst;
    logic       tick_1hz;
    logic       ped_req;
    logic       night_mode;
    logic [2:0] main_light;
    logic [2:0] side_light;
    logic [3:0] remain_tens;
    logic [3:0] remain_ones;
    logic       ped_pending;
    phase_e     phase;

    int checks = 0;
    int errors = 0;

    traffic_phase_scheduler #(
        .T_MAIN_G  (25),
        .T_SIDE_G  (20),
        .T_YEL     (3),
        .T_ALL_RED (2),
        .T_MIN_G   (10),
        .CW        (7)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .tick_1hz    (tick_1hz),
        .ped_req     (ped_req),
        .night_mode  (night_mode),
        .main_light  (main_light),
        .side_light  (side_light),
        .remain_tens (remain_tens),
        .remain_ones (remain_ones),
        .ped_pending (ped_pending),
        .phase       (phase)
    );

    // ---------------- clock / reset / time base ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // tick_1hz high for one clk out of every four; changes 1 time unit after
    // the rising edge so the value at an edge is the one the DUT samples.
    initial begin
        int div;
        div      = 0;
        tick_1hz = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (div == 3) begin
                tick_1hz = 1'b1;
                div      = 0;
            end else begin
                tick_1hz = 1'b0;
                div      = div + 1;
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Lights must never show more than one aspect per road, and a green on
    // one road requires red on the other.
    always @(negedge clk) begin
        if (!rst) begin
            checks++;
            if (!$onehot0(main_light) || !$onehot0(side_light) ||
                (main_light == LT_G && side_light != LT_R) ||
                (side_light == LT_G && main_light != LT_R)) begin
                errors++;
                $display("FAIL light_onehot: main=%b side=%b", main_light, side_light);
            end
        end
    end

    // ---------------- expected-value helpers (model only) ----------------
    function automatic logic [2:0] exp_main(input phase_e p, input logic b);
        case (p)
            MAIN_G:  return LT_G;
            MAIN_Y:  return LT_Y;
            NIGHT:   return b ? LT_Y : LT_OFF;
            default: return LT_R;
        endcase
    endfunction

    function automatic logic [2:0] exp_side(input phase_e p, input logic b);
        case (p)
            SIDE_G:  return LT_G;
            SIDE_Y:  return LT_Y;
            NIGHT:   return b ? LT_Y : LT_OFF;
            default: return LT_R;
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Wait for the next tick edge, then one more clk so the registered lights
    // and digits reflect the state updated at that tick.
    task automatic wait_tick();
        int n;
        n = 0;
        @(posedge clk);
        while (tick_1hz !== 1'b1 && n < 8) begin
            @(posedge clk);
            n++;
        end
        if (n >= 8) begin
            checks++;
            errors++;
            $display("FAIL tick_timeout: no tick within 8 clks");
        end
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ticks(input int n);
        for (int i = 0; i < n; i++) wait_tick();
    endtask

    task automatic pulse_ped();
        @(negedge clk);
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        #1;
    endtask

    // Pulse ped_req in exactly the cycle whose rising edge carries a tick.
    task automatic pulse_ped_on_tick();
        int n;
        n = 0;
        @(negedge clk);
        while (tick_1hz !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (n >= 8) begin
            checks++;
            errors++;
            $display("FAIL ped_tick_timeout: no tick within 8 clks");
        end
        ped_req = 1'b1;
        @(negedge clk);
        ped_req = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic advance_to(input phase_e target, input int max_ticks);
        int n;
        n = 0;
        while (phase !== target && n < max_ticks) begin
            wait_tick();
            n++;
        end
        checks++;
        if (phase !== target) begin
            errors++;
            $display("FAIL advance_to: phase=%0d required %0d", phase, target);
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst        = 1'b1;
        ped_req    = 1'b0;
        night_mode = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if (phase !== RED2) begin errors++; $display("FAIL reset_phase: %0d required %0d", phase, RED2); end
        checks++; if (main_light !== LT_R) begin errors++; $display("FAIL reset_main: %b required %b", main_light, LT_R); end
        checks++; if (side_light !== LT_R) begin errors++; $display("FAIL reset_side: %b required %b", side_light, LT_R); end
        checks++; if (remain_tens !== 4'd0 || remain_ones !== 4'd2) begin errors++; $display("FAIL reset_remain: %0d%0d required 02", remain_tens, remain_ones); end
        checks++; if (ped_pending !== 1'b0) begin errors++; $display("FAIL reset_ped: %b required 0", ped_pending); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    // One full unassisted cycle from reset: RED2 2, then the 55-tick period
    // back to the start of MAIN_G, checking every tick.
    task automatic test_normal_cycle();
        phase_e ph_tab [6] = '{MAIN_G, MAIN_Y, RED1, SIDE_G, SIDE_Y, RED2};
        int     d_tab  [6] = '{25, 3, 2, 20, 3, 2};
        int     idx;
        int     rem;
        idx = 5;
        rem = 2;
        for (int t = 1; t <= 57; t++) begin
            wait_tick();
            if (rem == 1) begin
                idx = (idx + 1) % 6;
                rem = d_tab[idx];
            end else begin
                rem = rem - 1;
            end
            checks++; if (phase !== ph_tab[idx]) begin errors++; $display("FAIL cycle_phase t=%0d: %0d required %0d", t, phase, ph_tab[idx]); end
            checks++; if (remain_tens !== 4'(rem / 10)) begin errors++; $display("FAIL cycle_tens t=%0d: %0d required %0d", t, remain_tens, rem / 10); end
            checks++; if (remain_ones !== 4'(rem % 10)) begin errors++; $display("FAIL cycle_ones t=%0d: %0d required %0d", t, remain_ones, rem % 10); end
            checks++; if (main_light !== exp_main(ph_tab[idx], 1'b0)) begin errors++; $display("FAIL cycle_main t=%0d: %b required %b", t, main_light, exp_main(ph_tab[idx], 1'b0)); end
            checks++; if (side_light !== exp_side(ph_tab[idx], 1'b0)) begin errors++; $display("FAIL cycle_side t=%0d: %b required %b", t, side_light, exp_side(ph_tab[idx], 1'b0)); end
        end
    endtask

    // Starts at MAIN_G with 25 remaining. Request after tick 3, held until
    // elapsed reaches 10, so MAIN_Y begins at tick 10.
    task automatic test_ped_min_green();
        wait_ticks(3);
        pulse_ped();
        checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL pmin_latch: %b required 1", ped_pending); end
        for (int k = 4; k <= 9; k++) begin
            wait_tick();
            checks++; if (phase !== MAIN_G) begin errors++; $display("FAIL pmin_hold k=%0d: %0d required %0d", k, phase, MAIN_G); end
            checks++; if (remain_tens !== 4'((25 - k) / 10) || remain_ones !== 4'((25 - k) % 10)) begin errors++; $display("FAIL pmin_remain k=%0d: %0d%0d required %0d", k, remain_tens, remain_ones, 25 - k); end
        end
        wait_tick();
        checks++; if (phase !== MAIN_Y) begin errors++; $display("FAIL pmin_cut: %0d required %0d", phase, MAIN_Y); end
        checks++; if (remain_tens !== 4'd0 || remain_ones !== 4'd3) begin errors++; $display("FAIL pmin_yel_remain: %0d%0d required 03", remain_tens, remain_ones); end
        wait_ticks(3);
        checks++; if (phase !== RED1 || ped_pending !== 1'b1) begin errors++; $display("FAIL pmin_red1: phase=%0d ped=%b required %0d/1", phase, ped_pending, RED1); end
        wait_ticks(2);
        checks++; if (phase !== SIDE_G) begin errors++; $display("FAIL pmin_side: %0d required %0d", phase, SIDE_G); end
        checks++; if (ped_pending !== 1'b0) begin errors++; $display("FAIL pmin_clear: %b required 0", ped_pending); end
    endtask

    // Starts at SIDE_G with 20 remaining. Request during SIDE_G does not
    // disturb it and is serviced at tick 10 of the next MAIN_G.
    task automatic test_ped_during_side();
        wait_ticks(5);
        pulse_ped();
        checks++; if (ped_pending !== 1'b1 || phase !== SIDE_G) begin errors++; $display("FAIL pside_latch: ped=%b phase=%0d required 1/%0d", ped_pending, phase, SIDE_G); end
        wait_ticks(15);
        checks++; if (phase !== SIDE_Y) begin errors++; $display("FAIL pside_full_green: %0d required %0d", phase, SIDE_Y); end
        wait_ticks(5);
        checks++; if (phase !== MAIN_G || ped_pending !== 1'b1) begin errors++; $display("FAIL pside_main: phase=%0d ped=%b required %0d/1", phase, ped_pending, MAIN_G); end
        wait_ticks(9);
        checks++; if (phase !== MAIN_G || remain_tens !== 4'd1 || remain_ones !== 4'd6) begin errors++; $display("FAIL pside_hold: phase=%0d remain=%0d%0d required %0d/16", phase, remain_tens, remain_ones, MAIN_G); end
        wait_tick();
        checks++; if (phase !== MAIN_Y) begin errors++; $display("FAIL pside_cut: %0d required %0d", phase, MAIN_Y); end
        wait_ticks(5);
        checks++; if (phase !== SIDE_G || ped_pending !== 1'b0) begin errors++; $display("FAIL pside_clear: phase=%0d ped=%b required %0d/0", phase, ped_pending, SIDE_G); end
    endtask

    // Starts at SIDE_G with 20 remaining. Request after MAIN_G tick 15 is
    // already past the minimum, so MAIN_Y follows on the next tick.
    task automatic test_ped_late();
        wait_ticks(25);
        checks++; if (phase !== MAIN_G || ped_pending !== 1'b0) begin errors++; $display("FAIL plate_main: phase=%0d ped=%b required %0d/0", phase, ped_pending, MAIN_G); end
        wait_ticks(15);
        pulse_ped();
        checks++; if (phase !== MAIN_G || remain_tens !== 4'd1 || remain_ones !== 4'd0) begin errors++; $display("FAIL plate_pre: phase=%0d remain=%0d%0d required %0d/10", phase, remain_tens, remain_ones, MAIN_G); end
        wait_tick();
        checks++; if (phase !== MAIN_Y) begin errors++; $display("FAIL plate_cut: %0d required %0d", phase, MAIN_Y); end
        checks++; if (main_light !== LT_Y || side_light !== LT_R) begin errors++; $display("FAIL plate_lights: main=%b side=%b required 010/001", main_light, side_light); end
        wait_ticks(5);
        checks++; if (phase !== SIDE_G || ped_pending !== 1'b0) begin errors++; $display("FAIL plate_clear: phase=%0d ped=%b required %0d/0", phase, ped_pending, SIDE_G); end
    endtask

    // Starts at SIDE_G with 20 remaining. Runs a full unassisted cycle to
    // RED1 with 1 remaining, then requests on the tick that enters SIDE_G.
    task automatic test_ped_coincident();
        wait_ticks(25);
        checks++; if (phase !== MAIN_G) begin errors++; $display("FAIL pco_main: %0d required %0d", phase, MAIN_G); end
        wait_ticks(25);
        checks++; if (phase !== MAIN_Y) begin errors++; $display("FAIL pco_full_green: %0d required %0d", phase, MAIN_Y); end
        wait_ticks(4);
        checks++; if (phase !== RED1 || remain_ones !== 4'd1) begin errors++; $display("FAIL pco_red1: phase=%0d ones=%0d required %0d/1", phase, remain_ones, RED1); end
        pulse_ped_on_tick();
        checks++; if (phase !== SIDE_G) begin errors++; $display("FAIL pco_side: %0d required %0d", phase, SIDE_G); end
        checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL pco_keep: %b required 1", ped_pending); end
        wait_tick();
        checks++; if (ped_pending !== 1'b1) begin errors++; $display("FAIL pco_keep2: %b required 1", ped_pending); end
    endtask

    // Starts at SIDE_G with 19 remaining. night_mode raised mid-green must
    // let the day cycle finish through RED2 before NIGHT.
    task automatic test_night();
        night_mode = 1'b1;
        wait_ticks(19);
        checks++; if (phase !== SIDE_Y || remain_ones !== 4'd3) begin errors++; $display("FAIL night_no_abort: phase=%0d ones=%0d required %0d/3", phase, remain_ones, SIDE_Y); end
        wait_ticks(3);
        checks++; if (phase !== RED2 || remain_ones !== 4'd2) begin errors++; $display("FAIL night_red2: phase=%0d ones=%0d required %0d/2", phase, remain_ones, RED2); end
        wait_ticks(2);
        checks++; if (phase !== NIGHT) begin errors++; $display("FAIL night_enter: %0d required %0d", phase, NIGHT); end
        checks++; if (remain_tens !== 4'd0 || remain_ones !== 4'd0) begin errors++; $display("FAIL night_remain: %0d%0d required 00", remain_tens, remain_ones); end
        checks++; if (main_light !== LT_Y || side_light !== LT_Y) begin errors++; $display("FAIL night_blink_on: main=%b side=%b required 010/010", main_light, side_light); end
        wait_tick();
        checks++; if (main_light !== LT_OFF || side_light !== LT_OFF || phase !== NIGHT) begin errors++; $display("FAIL night_blink_off: main=%b side=%b phase=%0d required 000/000/%0d", main_light, side_light, phase, NIGHT); end
        wait_tick();
        checks++; if (main_light !== LT_Y || side_light !== LT_Y) begin errors++; $display("FAIL night_blink_on2: main=%b side=%b required 010/010", main_light, side_light); end
        night_mode = 1'b0;
        wait_tick();
        checks++; if (phase !== RED2 || remain_ones !== 4'd2) begin errors++; $display("FAIL night_exit: phase=%0d ones=%0d required %0d/2", phase, remain_ones, RED2); end
        checks++; if (main_light !== LT_R || side_light !== LT_R) begin errors++; $display("FAIL night_exit_lights: main=%b side=%b required 001/001", main_light, side_light); end
        wait_ticks(2);
        checks++; if (phase !== MAIN_G || remain_tens !== 4'd2 || remain_ones !== 4'd5) begin errors++; $display("FAIL night_resume: phase=%0d remain=%0d%0d required %0d/25", phase, remain_tens, remain_ones, MAIN_G); end
    endtask

    task automatic test_reset_mid_side();
        advance_to(SIDE_G, 60);
        wait_ticks(5);
        checks++; if (side_light !== LT_G) begin errors++; $display("FAIL rmid_pre: side=%b required 100", side_light); end
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++; if (phase !== RED2) begin errors++; $display("FAIL rmid_phase: %0d required %0d", phase, RED2); end
        checks++; if (main_light !== LT_R || side_light !== LT_R) begin errors++; $display("FAIL rmid_lights: main=%b side=%b required 001/001", main_light, side_light); end
        checks++; if (remain_tens !== 4'd0 || remain_ones !== 4'd2) begin errors++; $display("FAIL rmid_remain: %0d%0d required 02", remain_tens, remain_ones); end
        checks++; if (ped_pending !== 1'b0) begin errors++; $display("FAIL rmid_ped: %b required 0", ped_pending); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (phase !== RED2 || main_light !== LT_R || side_light !== LT_R) begin errors++; $display("FAIL rmid_after: phase=%0d main=%b side=%b required %0d/001/001", phase, main_light, side_light, RED2); end
        wait_tick();
        checks++; if (phase !== RED2 || remain_ones !== 4'd1) begin errors++; $display("FAIL rmid_red2: phase=%0d ones=%0d required %0d/1", phase, remain_ones, RED2); end
        wait_tick();
        checks++; if (phase !== MAIN_G || main_light !== LT_G || side_light !== LT_R) begin errors++; $display("FAIL rmid_main: phase=%0d main=%b side=%b required %0d/100/001", phase, main_light, side_light, MAIN_G); end
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_normal_cycle();
        test_ped_min_green();
        test_ped_during_side();
        test_ped_late();
        test_ped_coincident();
        test_night();
        test_reset_mid_side();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
